median_sort_array: RTL and testbench

- Running-median datapath for the FIFO-based median filter.
- Holds a window of WIN samples in ascending sorted order, each tagged with an age.
- On every accepted input it removes the oldest sample and inserts the new one at its sorted position, using per-cell 2-bit shift selects.
- Sits between the sample source (valid/ready) and the median consumer (valid/ready).

---
 rtl/median_pkg.sv | 18 +
 rtl/median_cell.sv | 47 ++++
 rtl/median_sort_array.sv | 112 +++++++++++
 tb/tb_median_sort_array.sv | 138 +++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// median_pkg: shift-select encoding, default window sizing and a clog2 helper
// shared by the running-median array and its cells.
package median_pkg;
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_UP   = 2'b01,
        SEL_DOWN = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;
    localparam int WIN_DEF = 5;
    localparam int DW_DEF = 8;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/median_cell.sv
// median_cell: one slot of the sorted window (value, age, valid) updated through
// a 4:1 hold/up/down/load select; exposes its value <= in_data compare bit.
module median_cell
    import median_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    sel,
    input  logic          inc,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] up_value,
    input  logic [AW-1:0] up_age,
    input  logic          up_valid,
    input  logic [DW-1:0] down_value,
    input  logic [AW-1:0] down_age,
    input  logic          down_valid,
    output logic [DW-1:0] value,
    output logic [AW-1:0] age,
    output logic          valid,
    output logic          le
);
    logic [DW-1:0] nxt_value;
    logic [AW-1:0] nxt_age;
    logic          nxt_valid;
    // Invalid slots keep age 0 so only live samples ever approach the oldest age.
    always_comb begin
        nxt_value = sel == SEL_LOAD ? in_data : sel == SEL_UP ? up_value : sel == SEL_DOWN ? down_value : value;
        nxt_age = sel == SEL_LOAD ? '0 : sel == SEL_UP ? up_age + AW'(up_valid) :
                  sel == SEL_DOWN ? down_age + AW'(down_valid) : age + AW'(inc & valid);
        nxt_valid = sel == SEL_LOAD ? 1'b1 : sel == SEL_UP ? up_valid : sel == SEL_DOWN ? down_valid : valid;
        le = valid && value <= in_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '1;
            age <= '0;
            valid <= 1'b0;
        end else begin
            value <= nxt_value;
            age <= nxt_age;
            valid <= nxt_valid;
        end
    end
endmodule

// File: rtl/median_sort_array.sv
// median_sort_array: sorted running-median window; each accepted sample evicts the oldest.
// Define MEDIAN_MINMAX_EN to add out_min/out_max taps on the window extremes.
module median_sort_array
    import median_pkg::*;
#(
    parameter int WIN = WIN_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_median,
`ifdef MEDIAN_MINMAX_EN
    output logic [DW-1:0]            out_min,
    output logic [DW-1:0]            out_max,
`endif
    output logic [clog2(WIN+1)-1:0] fill_cnt
);
    localparam int AW = clog2(WIN);
    localparam int CW = clog2(WIN + 1);
    localparam int MID = (WIN - 1) / 2;
    logic [DW-1:0] value [WIN];
    logic [AW-1:0] age [WIN];
    logic [WIN-1:0] valid, le;
    sel_t sel [WIN];
    logic [AW-1:0] o, p;
    logic accept, full;
    function automatic logic [DW-1:0] next_of(input sel_t s, input logic [DW-1:0] d, lo, self, hi);
        return s == SEL_LOAD ? d : s == SEL_UP ? lo : s == SEL_DOWN ? hi : self;
    endfunction
    assign full = fill_cnt == CW'(WIN);
    assign in_ready = !(out_valid && !out_ready);
    assign accept = in_valid && in_ready;
    // o: slot to evict; p: sorted position of the new sample once o is gone.
    always_comb begin
        o = AW'(WIN - 1);
        p = '0;
        for (int i = 0; i < WIN; i++) if (full && age[i] == AW'(WIN - 1)) o = AW'(i);
        for (int i = 0; i < WIN; i++) if (le[i] && AW'(i) != o) p = p + AW'(1);
        for (int i = 0; i < WIN; i++) begin
            sel[i] = SEL_HOLD;
            if (accept) sel[i] = AW'(i) == p ? SEL_LOAD :
                                 (p < o && AW'(i) > p && AW'(i) <= o) ? SEL_UP :
                                 (p > o && AW'(i) >= o && AW'(i) < p) ? SEL_DOWN : SEL_HOLD;
        end
    end
    for (genvar g = 0; g < WIN; g++) begin : g_cell
        logic [DW-1:0] up_value, down_value;
        logic [AW-1:0] up_age, down_age;
        logic up_valid, down_valid;
        if (g == 0) begin : g_bot
            assign up_value = '1;
            assign up_age = '0;
            assign up_valid = 1'b0;
        end else begin : g_mid_lo
            assign up_value = value[g-1];
            assign up_age = age[g-1];
            assign up_valid = valid[g-1];
        end
        if (g == WIN - 1) begin : g_top
            assign down_value = '1;
            assign down_age = '0;
            assign down_valid = 1'b0;
        end else begin : g_mid_hi
            assign down_value = value[g+1];
            assign down_age = age[g+1];
            assign down_valid = valid[g+1];
        end
        median_cell #(.DW(DW), .AW(AW)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .sel       (sel[g]),
            .inc       (accept),
            .in_data   (in_data),
            .up_value  (up_value),
            .up_age    (up_age),
            .up_valid  (up_valid),
            .down_value(down_value),
            .down_age  (down_age),
            .down_valid(down_valid),
            .value     (value[g]),
            .age       (age[g]),
            .valid     (valid[g]),
            .le        (le[g])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            out_valid <= 1'b0;
            out_median <= '0;
`ifdef MEDIAN_MINMAX_EN
            out_min <= '0;
            out_max <= '0;
`endif
        end else if (accept) begin
            fill_cnt <= full ? fill_cnt : fill_cnt + CW'(1);
            out_valid <= full || fill_cnt == CW'(WIN - 1);
            out_median <= next_of(sel[MID], in_data, value[MID-1], value[MID], value[MID+1]);
`ifdef MEDIAN_MINMAX_EN
            out_min <= next_of(sel[0], in_data, value[0], value[0], value[1]);
            out_max <= next_of(sel[WIN-1], in_data, value[WIN-2], value[WIN-1], value[WIN-1]);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_sort_array.sv
// tb_median_sort_array: scoreboard bench; a sorted-window model queues expected medians,
// which are compared as the DUT hands them off.
module tb_median_sort_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [7:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [7:0] out_median;
    logic [2:0] fill_cnt;
`ifdef MEDIAN_MINMAX_EN
    logic [7:0] out_min, out_max;
`endif
    int n_checks = 0;
    int n_pass = 0;
    int fill = 0;
    logic [7:0] win [$];
    logic [7:0] exp_q [$];
    median_sort_array #(.WIN(5), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_median(out_median),
`ifdef MEDIAN_MINMAX_EN
        .out_min   (out_min),
        .out_max   (out_max),
`endif
        .fill_cnt  (fill_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    function automatic logic [7:0] med(input logic [7:0] q [$]);
        logic [7:0] s [$];
        s = q;
        s.sort();
        return s[2];
    endfunction
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = d;
        win.push_back(d);
        if (win.size() > 5) void'(win.pop_front());
        if (fill < 5) fill++;
        if (fill == 5) exp_q.push_back(med(win));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("fill_cnt", 32'(fill_cnt), 32'(fill));
        check("out_valid", 32'(out_valid), 32'(fill == 5));
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        win.delete();
        exp_q.delete();
        fill = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_fill_cnt", 32'(fill_cnt), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_median", 32'(out_median), 32'd0);
    endtask
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else check("median", 32'(out_median), 32'(exp_q.pop_front()));
        end
    end
    initial begin
        logic [7:0] fill_seq [5] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
        logic [7:0] tie_seq [7] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0};
        logic [7:0] edge_seq [6] = '{8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd128};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_fill_cnt", 32'(fill_cnt), 32'd0);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_median", 32'(out_median), 32'd0);
        foreach (fill_seq[i]) push(fill_seq[i]);
        push(8'd2);
        push(8'd8);
        do_reset();
        foreach (tie_seq[i]) push(tie_seq[i]);
        foreach (edge_seq[i]) push(edge_seq[i]);
        push(8'd60);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_median", 32'(out_median), 32'(exp_q[0]));
            in_valid = 1'b1;
            in_data = 8'(k * 50 + 7);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_fill_cnt", 32'(fill_cnt), 32'd5);
        for (int k = 0; k < 20; k++) push(8'($urandom_range(0, 255)));
        do_reset();
        push(8'd7);
        push(8'd8);
        push(8'd9);
        do_reset();
        push(8'd10);
        push(8'd20);
        push(8'd30);
        push(8'd40);
        push(8'd50);
        repeat (3) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
